// File: rtl/data_memory_sync.sv
// Byte-addressable data memory for the MEM stage: clocked stores, registered loads, fault reporting and a post-reset clear sweep.
// Optional build macro DMEM_MISALIGN_TRAP_EN makes misaligned halfword/word accesses fault instead of completing.
module data_memory_sync #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] endereco,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              read_valid,
    output logic              fault,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int CNT_W = $clog2(WORDS);
    localparam int CMP_W = ((ADDR_W > IDX_W) ? ADDR_W : IDX_W) + 2;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              read_valid_q, read_valid_d;
    logic              fault_q, fault_d;

    logic [7:0]        mem [DEPTH_BYTES];

    logic              decode_ok;
    logic              out_of_range;
    logic              misaligned;
    logic [2:0]        size;
    logic [CMP_W-1:0]  last_addr;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  byte_addr [4];
    logic [31:0]       raw;
    logic              accept_rd, accept_wr;
    logic [3:0]        wr_en;
    logic [IDX_W-1:0]  wr_addr [4];
    logic [7:0]        wr_byte [4];

    // Request decode and legality: size, range (no address wrap) and optional alignment.
    always_comb begin
        decode_ok = 1'b0;
        if (MemRead) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: decode_ok = 1'b1;
                default:                                decode_ok = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: decode_ok = 1'b1;
                default:                decode_ok = 1'b0;
            endcase
        end

        case (funct3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase

        last_addr    = {{(CMP_W-ADDR_W){1'b0}}, endereco} + CMP_W'(size) - CMP_W'(1);
        out_of_range = (last_addr >= CMP_W'(DEPTH_BYTES));

`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = ((funct3[1:0] == 2'b01) && endereco[0]) ||
                     ((funct3[1:0] == 2'b10) && (endereco[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif

        idx = endereco[IDX_W-1:0];
        for (int k = 0; k < 4; k++) begin
            byte_addr[k] = idx + IDX_W'(k);
        end
    end

    // Sequencing: the clear sweep, request acceptance and the next registered response.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        read_data_d  = '0;
        read_valid_d = 1'b0;
        fault_d      = 1'b0;
        accept_rd    = 1'b0;
        accept_wr    = 1'b0;
        raw          = '0;

        case (state_q)
            CLEAR: begin
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WORDS - 1)) begin
                    state_d = READY;
                    count_d = '0;
                end
            end
            READY: begin
                if (MemRead || MemWrite) begin
                    if ((MemRead && MemWrite) || !decode_ok || out_of_range || misaligned) begin
                        fault_d = 1'b1;
                    end else begin
                        accept_rd = MemRead;
                        accept_wr = MemWrite;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase

        for (int k = 0; k < 4; k++) begin
            if (3'(k) < size) begin
                raw[8*k +: 8] = mem[byte_addr[k]];
            end
        end

        if (accept_rd) begin
            read_valid_d = 1'b1;
            case (funct3)
                3'b000:  read_data_d = {{24{raw[7]}}, raw[7:0]};
                3'b001:  read_data_d = {{16{raw[15]}}, raw[15:0]};
                3'b100:  read_data_d = {24'b0, raw[7:0]};
                3'b101:  read_data_d = {16'b0, raw[15:0]};
                default: read_data_d = raw;
            endcase
        end
    end

    // Byte write lanes: the clear sweep zeroes a whole word, stores write their low bytes.
    always_comb begin
        wr_en = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wr_addr[k] = byte_addr[k];
            wr_byte[k] = write_data[8*k +: 8];
        end
        if (reset_n) begin
            if (state_q == CLEAR) begin
                wr_en = 4'b1111;
                for (int k = 0; k < 4; k++) begin
                    wr_addr[k] = {count_q, 2'(k)};
                    wr_byte[k] = 8'h00;
                end
            end else if (accept_wr) begin
                for (int k = 0; k < 4; k++) begin
                    wr_en[k] = (3'(k) < size);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= CLEAR;
            count_q      <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            fault_q      <= fault_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
                mem[wr_addr[k]] <= wr_byte[k];
            end
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign fault      = fault_q;
    assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_data_memory_sync.sv
// Bench for data_memory_sync: byte-array reference model compared every cycle, plus directed literal checks.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_data_memory_sync;

    localparam int DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] endereco;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_valid;
    logic        fault;
    logic        busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    data_memory_sync #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .endereco   (endereco),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
        .fault      (fault),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain byte array plus a count of clear cycles still owed.
    logic [7:0]  m_mem [DEPTH];
    int          clear_left = 0;
    bit          model_live = 0;
    logic [31:0] e_rd = '0;
    logic        e_rv = 1'b0;
    logic        e_f  = 1'b0;
    logic        e_busy = 1'b1;

    always @(posedge clock) begin
        e_rd = '0;
        e_rv = 1'b0;
        e_f  = 1'b0;
        if (!reset_n) begin
            clear_left = DEPTH / 4;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
            model_live = 1;
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (MemRead || MemWrite) begin
            bit     legal;
            int     nbytes;
            longint last;
            longint val;
            int     a;
            if (MemRead && MemWrite) legal = 0;
            else if (MemRead) legal = (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            else legal = (funct3 inside {3'd0, 3'd1, 3'd2});
            nbytes = (funct3[1:0] == 2'd0) ? 1 : (funct3[1:0] == 2'd1) ? 2 : 4;
            last = longint'({32'd0, endereco}) + nbytes - 1;
            if (last >= DEPTH) legal = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
            if (legal && (endereco % nbytes) != 0) legal = 0;
`endif
            if (!legal) begin
                e_f = 1'b1;
            end else begin
                a = int'(endereco);
                if (MemWrite) begin
                    for (int i = 0; i < nbytes; i++) m_mem[a + i] = write_data[8*i +: 8];
                end else begin
                    val = 0;
                    for (int i = 0; i < nbytes; i++) val = val + longint'(m_mem[a + i]) * (longint'(1) << (8 * i));
                    if (!funct3[2] && nbytes < 4 && val >= (longint'(1) << (8 * nbytes - 1)))
                        val = val - (longint'(1) << (8 * nbytes));
                    e_rd = val[31:0];
                    e_rv = 1'b1;
                end
            end
        end
        e_busy = (!reset_n) || (clear_left > 0);
    end

    always @(negedge clock) begin
        if (model_live) begin
            check("model_read_data", read_data, e_rd);
            check("model_read_valid", {31'd0, read_valid}, {31'd0, e_rv});
            check("model_fault", {31'd0, fault}, {31'd0, e_f});
            check("model_busy", {31'd0, busy}, {31'd0, e_busy});
        end
    end

    // Present one request for one cycle; returns at the negedge where its response is visible.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        MemRead    = rd;
        MemWrite   = wr;
        funct3     = f3;
        endereco   = addr;
        write_data = wdata;
        @(negedge clock);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [31:0] exp_data,
                                input logic exp_valid, input logic exp_fault);
        check({name, "_data"}, read_data, exp_data);
        check({name, "_valid"}, {31'd0, read_valid}, {31'd0, exp_valid});
        check({name, "_fault"}, {31'd0, fault}, {31'd0, exp_fault});
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clock);
        end
        check(name, cnt, DEPTH / 4);
    endtask

    initial begin
        reset_n    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        funct3     = 3'd0;
        endereco   = '0;
        write_data = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", {31'd0, busy}, 32'd1);
        check_output("reset", 32'h0, 1'b0, 1'b0);

        reset_n = 1'b1;
        count_busy("clear_length");

        apply_stimulus(1, 0, 3'b010, 32'd0, 0);           check_output("lw0_after_clear", 32'h0, 1, 0);
        apply_stimulus(1, 0, 3'b010, 32'd1020, 0);        check_output("lw1020_after_clear", 32'h0, 1, 0);

        apply_stimulus(0, 1, 3'b010, 32'd16, 32'h8081F0F1); check_output("sw16", 32'h0, 0, 0);
        apply_stimulus(1, 0, 3'b000, 32'd16, 0);          check_output("lb16", 32'hFFFFFFF1, 1, 0);
        apply_stimulus(1, 0, 3'b100, 32'd16, 0);          check_output("lbu16", 32'h000000F1, 1, 0);
        apply_stimulus(1, 0, 3'b001, 32'd18, 0);          check_output("lh18", 32'hFFFF8081, 1, 0);
        apply_stimulus(1, 0, 3'b101, 32'd18, 0);          check_output("lhu18", 32'h00008081, 1, 0);
        apply_stimulus(1, 0, 3'b010, 32'd16, 0);          check_output("lw16", 32'h8081F0F1, 1, 0);

        apply_stimulus(0, 1, 3'b010, 32'd32, 32'h11223344); check_output("sw32", 32'h0, 0, 0);
        apply_stimulus(0, 1, 3'b000, 32'd33, 32'h555555AA); check_output("sb33", 32'h0, 0, 0);
        apply_stimulus(0, 1, 3'b001, 32'd34, 32'h7777BEEF); check_output("sh34", 32'h0, 0, 0);
        apply_stimulus(1, 0, 3'b010, 32'd32, 0);          check_output("lw32_partial", 32'hBEEFAA44, 1, 0);

        apply_stimulus(1, 0, 3'b010, 32'd1021, 0);        check_output("lw1021_range", 32'h0, 0, 1);
        apply_stimulus(1, 1, 3'b010, 32'd16, 32'hFFFFFFFF); check_output("rd_wr_both", 32'h0, 0, 1);
        apply_stimulus(1, 0, 3'b010, 32'd16, 0);          check_output("lw16_unchanged", 32'h8081F0F1, 1, 0);
        apply_stimulus(1, 0, 3'b011, 32'd0, 0);           check_output("load_f3_011", 32'h0, 0, 1);
        apply_stimulus(0, 1, 3'b100, 32'd40, 32'h12345678); check_output("store_f3_100", 32'h0, 0, 1);
        apply_stimulus(1, 0, 3'b010, 32'd40, 0);          check_output("lw40_unchanged", 32'h0, 1, 0);
        apply_stimulus(1, 0, 3'b100, 32'd1023, 0);        check_output("lbu1023_edge", 32'h0, 1, 0);
        apply_stimulus(1, 0, 3'b001, 32'd1023, 0);        check_output("lh1023_range", 32'h0, 0, 1);
        apply_stimulus(1, 0, 3'b010, 32'hFFFFFFFD, 0);    check_output("lw_wrap_range", 32'h0, 0, 1);
        apply_stimulus(0, 0, 3'b000, 32'd0, 0);           check_output("idle", 32'h0, 0, 0);

        apply_stimulus(0, 1, 3'b010, 32'd0, 32'hDEADBEEF); check_output("sw0", 32'h0, 0, 0);
        apply_stimulus(1, 0, 3'b010, 32'd1, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check_output("lw1_misaligned", 32'h0, 0, 1);
`else
        check_output("lw1_misaligned", 32'h00DEADBE, 1, 0);
`endif

        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                MemWrite   = 1'b1;
                funct3     = 3'b010;
                endereco   = 32'd0;
                write_data = 32'h12345678;
            end else begin
                MemWrite = 1'b0;
            end
            @(negedge clock);
        end
        MemWrite = 1'b0;
        check("midclear_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        count_busy("clear_length_restart");
        apply_stimulus(1, 0, 3'b010, 32'd0, 0);           check_output("lw0_store_dropped", 32'h0, 1, 0);
        apply_stimulus(1, 0, 3'b010, 32'd16, 0);          check_output("lw16_cleared", 32'h0, 1, 0);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
